udp_tx: RTL

- Upstream transmit framer that feeds the net_rtrans_* input stream of the network layer.
- Accepts a send request (destination IP, ports, payload length) plus a byte stream of payload.
- Resolves the destination MAC through the ARP cache query port, triggering an ARP request on a cache miss.
- Emits a complete Ethernet II + IPv4 + UDP frame, starting at the destination MAC. The MAC appends preamble, SFD and FCS.

---
 rtl/net_pkg.sv | 16 +
 rtl/ip_csum.sv | 14 +
 rtl/udp_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/net_pkg.sv
// net_pkg: shared framing constants, transmit FSM states and one's-complement fold helper
package net_pkg;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int MIN_FRAME_LEN = 60;
  localparam logic [15:0] MIN_PAY_LEN = 16'(MIN_FRAME_LEN - ETH_HDR_LEN - IP_HDR_LEN - UDP_HDR_LEN);
  typedef enum logic [3:0] {IDLE, QUERY, RESP, TRIG, CSUM, HDR, PAY, FILL, PAD, DROP} state_t;
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] t;
    t = 17'(s[15:0]) + 17'(s[19:16]);
    return t[15:0] + 16'(t[16]);
  endfunction
endpackage

// File: rtl/ip_csum.sv
// ip_csum: combinational folded one's-complement sum of ten 16-bit words (words in, sum out)
module ip_csum
  import net_pkg::*;
(
  input  logic [159:0] words,
  output logic [15:0]  sum
);
  logic [19:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < 10; i++) acc = acc + 20'(words[16*i +: 16]);
    sum = csum_fold(acc);
  end
endmodule

// File: rtl/udp_tx.sv
// udp_tx: Ethernet/IPv4/UDP framer; send request + payload stream in, ARP query/trigger side ports, frame byte stream out
module udp_tx
  import net_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678,
  parameter logic [7:0] IP_TTL = 8'd64,
  parameter int ARP_RETRY_MAX = 3
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic        udp_treq_valid_in,
  output logic        udp_treq_ready_out,
  input  logic [31:0] udp_tdst_ip_in,
  input  logic [15:0] udp_tsrc_port_in,
  input  logic [15:0] udp_tdst_port_in,
  input  logic [15:0] udp_tlen_in,
  input  logic [7:0]  udp_tdata_in,
  input  logic        udp_tvalid_in,
  output logic        udp_tready_out,
  input  logic        udp_tlast_in,
  output logic        udp_terr_out,
  output logic [31:0] arp_query_ip_out,
  output logic        arp_query_valid_out,
  input  logic        arp_query_ready_in,
  input  logic [47:0] arp_response_mac_in,
  input  logic        arp_response_valid_in,
  output logic        arp_response_ready_out,
  input  logic        arp_response_err_in,
  output logic        trig_arp_qvalid_out,
  output logic [31:0] trig_arp_ip_out,
  input  logic        trig_arp_qready_in,
  output logic [7:0]  net_rtrans_data_out,
  output logic        net_rtrans_valid_out,
  input  logic        net_rtrans_ready_in,
  output logic        net_rtrans_last_out
);
  state_t state;
  logic [31:0] ip;
  logic [47:0] mac;
  logic [15:0] sport, dport, len, ident, csum, pcnt, n, tot_len, udp_len, sum;
  logic [5:0] cnt;
  logic [7:0] retry;
  logic drain, terr, at_len, net_hs;
  logic [335:0] hdr;
  assign tot_len = len + 16'(IP_HDR_LEN + UDP_HDR_LEN);
  assign udp_len = len + 16'(UDP_HDR_LEN);
  assign n = pcnt + 16'd1;
  assign at_len = n == len;
  ip_csum u_csum (
    .words({16'h4500, tot_len, ident, 16'h4000, IP_TTL, IP_PROTO_UDP, 16'h0000, LOCAL_IP, ip}),
    .sum(sum)
  );
  assign hdr = {mac, LOCAL_MAC, ETH_TYPE_IPV4, 16'h4500, tot_len, ident, 16'h4000, IP_TTL,
                IP_PROTO_UDP, csum, LOCAL_IP, ip, sport, dport, udp_len, 16'h0000};
  always_comb begin
    udp_treq_ready_out = state == IDLE && !logic_rst;
    arp_query_valid_out = state == QUERY;
    arp_query_ip_out = ip;
    arp_response_ready_out = state == RESP;
    trig_arp_qvalid_out = state == TRIG;
    trig_arp_ip_out = ip;
    udp_terr_out = terr;
    udp_tready_out = state == PAY ? net_rtrans_ready_in : state == DROP;
    net_rtrans_valid_out = state inside {HDR, FILL, PAD} || (state == PAY && udp_tvalid_in);
    net_rtrans_data_out = state == HDR ? 8'(hdr >> {6'd41 - cnt, 3'b000}) :
                          state == PAY ? udp_tdata_in : 8'h00;
    net_rtrans_last_out = net_rtrans_valid_out &&
                          ((state inside {PAY, FILL} && at_len && len >= MIN_PAY_LEN) ||
                           (state == PAD && n == MIN_PAY_LEN));
    net_hs = net_rtrans_valid_out && net_rtrans_ready_in;
  end
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state <= IDLE;
      ip <= '0;
      mac <= '0;
      sport <= '0;
      dport <= '0;
      len <= '0;
      ident <= '0;
      csum <= '0;
      pcnt <= '0;
      cnt <= '0;
      retry <= '0;
      drain <= 1'b0;
      terr <= 1'b0;
    end else begin
      terr <= 1'b0;
      case (state)
        IDLE: if (udp_treq_valid_in) begin
          ip <= udp_tdst_ip_in;
          sport <= udp_tsrc_port_in;
          dport <= udp_tdst_port_in;
          len <= udp_tlen_in;
          retry <= '0;
          drain <= 1'b0;
          state <= QUERY;
        end
        QUERY: if (arp_query_ready_in) state <= RESP;
        RESP: if (arp_response_valid_in) begin
          if (!arp_response_err_in) begin
            mac <= arp_response_mac_in;
            state <= CSUM;
          end else if (retry < 8'(ARP_RETRY_MAX)) state <= TRIG;
          else begin
            terr <= 1'b1;
            state <= DROP;
          end
        end
        TRIG: if (trig_arp_qready_in) begin
          retry <= retry + 8'd1;
          state <= QUERY;
        end
        CSUM: begin
          csum <= ~sum;
          state <= HDR;
        end
        HDR: if (net_rtrans_ready_in) begin
          cnt <= cnt == 6'd41 ? 6'd0 : cnt + 6'd1;
          pcnt <= '0;
          if (cnt == 6'd41) state <= PAY;
        end
        // drain remembers that upstream still owes bytes after the frame (and any pad) ends
        PAY: if (net_hs) begin
          pcnt <= n;
          if (at_len) begin
            terr <= !udp_tlast_in;
            drain <= !udp_tlast_in;
            state <= len < MIN_PAY_LEN ? PAD : udp_tlast_in ? IDLE : DROP;
          end else if (udp_tlast_in) begin
            terr <= 1'b1;
            state <= FILL;
          end
        end
        FILL: if (net_rtrans_ready_in) begin
          pcnt <= n;
          if (at_len) state <= len < MIN_PAY_LEN ? PAD : IDLE;
        end
        PAD: if (net_rtrans_ready_in) begin
          pcnt <= n;
          if (n == MIN_PAY_LEN) state <= drain ? DROP : IDLE;
        end
        DROP: if (udp_tvalid_in && udp_tlast_in) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (net_hs && net_rtrans_last_out) begin
        ident <= ident + 16'd1;
        retry <= '0;
      end
    end
  end
endmodule
